// File: rtl/gate_sweep_ctrl_pkg.sv
// rtl/gate_sweep_ctrl_pkg.sv - shared state encodings and truth-table constants for the gate sweeper
package gate_sweep_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Two-input truth tables; bit k is the expected output for input vector k.
   localparam logic [3:0] TT_AND2  = 4'b1000;
   localparam logic [3:0] TT_OR2   = 4'b1110;
   localparam logic [3:0] TT_XOR2  = 4'b0110;
   localparam logic [3:0] TT_NAND2 = 4'b0111;

   function automatic int timer_width(input int settle_cycles);
      return $clog2(settle_cycles) + 1;
   endfunction

endpackage

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// rtl/gate_sweep_ctrl_settle_timer.sv - loadable down-counter with zero flag for per-vector settling
module settle_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - exhaustive input sweeper and truth-table checker for a small combinational gate
module gate_sweep_ctrl
   import gate_sweep_ctrl_pkg::*;
#(
   parameter int                    N_IN          = 2,
   parameter int                    SETTLE_CYCLES = 2,
   parameter logic [2**N_IN-1:0]    TRUTH         = 4'b1000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [N_IN-1:0] in_vec,
   input  logic            gate_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_cnt,
   output logic            fail_valid,
   output logic [N_IN-1:0] fail_vec
);

   localparam int              TW          = timer_width(SETTLE_CYCLES);
   localparam logic [TW-1:0]   SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
   localparam logic [N_IN-1:0] LAST_VEC    = '1;

   state_t          r_state;
   logic [N_IN-1:0] r_in_vec;
   logic            r_busy;
   logic            r_done;
   logic            r_pass;
   logic [N_IN:0]   r_err_cnt;
   logic            r_fail_valid;
   logic [N_IN-1:0] r_fail_vec;

   logic            w_mismatch;
   logic            w_last;
   logic [N_IN:0]   w_err_next;
   logic            w_tmr_load;
   logic            w_tmr_dec;
   logic            w_tmr_zero;

   assign w_mismatch = (gate_out != TRUTH[r_in_vec]);
   assign w_last     = (r_in_vec == LAST_VEC);
   assign w_err_next = r_err_cnt + (N_IN+1)'(w_mismatch);

   // The timer is reloaded whenever a fresh vector starts settling.
   assign w_tmr_load = ((r_state == ST_IDLE) && start) ||
                       ((r_state == ST_SAMPLE) && !w_last);
   assign w_tmr_dec  = (r_state == ST_SETTLE);

   settle_timer #(
      .W (TW)
   ) u_settle_timer (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_tmr_load),
      .i_load_val (SETTLE_LOAD),
      .i_dec      (w_tmr_dec),
      .o_zero     (w_tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_in_vec     <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err_cnt    <= '0;
         r_fail_valid <= 1'b0;
         r_fail_vec   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state      <= ST_SETTLE;
                  r_in_vec     <= '0;
                  r_busy       <= 1'b1;
                  r_pass       <= 1'b0;
                  r_err_cnt    <= '0;
                  r_fail_valid <= 1'b0;
               end
            end
            ST_SETTLE: begin
               if (w_tmr_zero) begin
                  r_state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               r_err_cnt <= w_err_next;
               if (w_mismatch && !r_fail_valid) begin
                  r_fail_valid <= 1'b1;
                  r_fail_vec   <= r_in_vec;
               end
               // pass must reflect this final sample, hence w_err_next.
               if (w_last) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_pass  <= (w_err_next == '0);
               end else begin
                  r_state  <= ST_SETTLE;
                  r_in_vec <= r_in_vec + N_IN'(1);
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_vec     = r_in_vec;
   assign busy       = r_busy;
   assign done       = r_done;
   assign pass       = r_pass;
   assign err_cnt    = r_err_cnt;
   assign fail_valid = r_fail_valid;
   assign fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - randomized self-checking bench for gate_sweep_ctrl against a truth-table reference model
module tb_gate_sweep_ctrl;
   import gate_sweep_ctrl_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start_a, start_b;
   logic [3:0] act_a, act_b;

   logic [1:0] in_vec_a, in_vec_b, fail_vec_a, fail_vec_b;
   logic [2:0] err_cnt_a, err_cnt_b;
   logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, fv_a, fv_b;
   logic       gate_a, gate_b;

   // Gate models: the actual behaviour is a 4-entry table, so faults are just altered tables.
   assign gate_a = act_a[in_vec_a];
   assign gate_b = act_b[in_vec_b];

   gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(2), .TRUTH(TT_AND2)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .in_vec(in_vec_a), .gate_out(gate_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_cnt_a),
      .fail_valid(fv_a), .fail_vec(fail_vec_a)
   );

   gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(1), .TRUTH(TT_XOR2)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .in_vec(in_vec_b), .gate_out(gate_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_cnt_b),
      .fail_valid(fv_b), .fail_vec(fail_vec_b)
   );

   int sel = 0;
   logic [1:0] o_in_vec, o_fail_vec;
   logic [2:0] o_err_cnt;
   logic       o_busy, o_done, o_pass, o_fv;

   always_comb begin
      o_in_vec = in_vec_a; o_fail_vec = fail_vec_a; o_err_cnt = err_cnt_a;
      o_busy = busy_a; o_done = done_a; o_pass = pass_a; o_fv = fv_a;
      if (sel != 0) begin
         o_in_vec = in_vec_b; o_fail_vec = fail_vec_b; o_err_cnt = err_cnt_b;
         o_busy = busy_b; o_done = done_b; o_pass = pass_b; o_fv = fv_b;
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_start(input logic v);
      if (sel == 0) start_a = v;
      else          start_b = v;
   endtask

   // One full sweep: reference results come from comparing the whole actual table with TRUTH.
   task automatic run_sweep(input int s, input logic [3:0] act, input bit inject, input string tag);
      int          settle, t_len, exp_err, exp_first;
      logic [3:0]  truth, diff;
      settle = (s == 0) ? 2 : 1;
      truth  = (s == 0) ? TT_AND2 : TT_XOR2;
      t_len  = 4 * (settle + 1);
      diff   = act ^ truth;
      exp_err = 0;
      exp_first = -1;
      for (int b = 0; b < 4; b++) begin
         if (diff[b]) begin
            exp_err++;
            if (exp_first < 0) exp_first = b;
         end
      end
      sel = s;
      if (s == 0) act_a = act;
      else        act_b = act;
      @(negedge clk);
      drive_start(1'b1);
      for (int k = 0; k <= t_len + 2; k++) begin
         @(negedge clk);
         if (k < t_len) begin
            check($sformatf("%s_vec_k%0d", tag, k), o_in_vec, k / (settle + 1));
            check($sformatf("%s_busy_k%0d", tag, k), o_busy, 1);
            check($sformatf("%s_done_k%0d", tag, k), o_done, 0);
         end
         if (k == 0) begin
            check({tag, "_clr_err"}, o_err_cnt, 0);
            check({tag, "_clr_fv"}, o_fv, 0);
            check({tag, "_clr_pass"}, o_pass, 0);
         end
         if (k >= t_len) begin
            check($sformatf("%s_done_k%0d", tag, k), o_done, (k == t_len));
            check($sformatf("%s_busy_k%0d", tag, k), o_busy, 0);
            check($sformatf("%s_vec_k%0d", tag, k), o_in_vec, 3);
            check($sformatf("%s_err_k%0d", tag, k), o_err_cnt, exp_err);
            check($sformatf("%s_pass_k%0d", tag, k), o_pass, (exp_err == 0));
            check($sformatf("%s_fv_k%0d", tag, k), o_fv, (exp_err != 0));
            if (exp_err != 0)
               check($sformatf("%s_fvec_k%0d", tag, k), o_fail_vec, exp_first);
         end
         drive_start(inject && ((k == 5) || (k == t_len)));
      end
      drive_start(1'b0);
   endtask

   task automatic reset_mid_sweep();
      int n_done;
      sel = 0;
      act_a = 4'b1111;
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (6) @(negedge clk);
      check("rst_pre_vec", in_vec_a, 2);
      check("rst_pre_err", err_cnt_a, 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_busy", busy_a, 0);
      check("rst_vec", in_vec_a, 0);
      check("rst_err", err_cnt_a, 0);
      check("rst_fv", fv_a, 0);
      check("rst_pass", pass_a, 0);
      n_done = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done_a) n_done++;
      end
      check("rst_no_done", n_done, 0);
      check("rst_idle_busy", busy_a, 0);
   endtask

   initial begin
      rst = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      act_a = TT_AND2;
      act_b = TT_XOR2;
      repeat (3) @(negedge clk);
      check("reset_vec", in_vec_a, 0);
      check("reset_busy", busy_a, 0);
      check("reset_done", done_a, 0);
      check("reset_pass", pass_a, 0);
      check("reset_err", err_cnt_a, 0);
      check("reset_fv", fv_a, 0);
      check("reset_fvec", fail_vec_a, 0);
      check("reset_b_busy", busy_b, 0);
      rst = 1'b0;

      run_sweep(0, TT_AND2, 1'b0, "and_clean");
      run_sweep(0, 4'b0000, 1'b0, "stuck0");
      run_sweep(0, 4'b1111, 1'b0, "stuck1");
      run_sweep(0, 4'b1111, 1'b1, "inject_stuck1");
      run_sweep(0, TT_AND2, 1'b0, "after_inject");
      reset_mid_sweep();
      run_sweep(0, TT_AND2, 1'b0, "after_rst");
      run_sweep(1, TT_XOR2, 1'b0, "xor_s1");

      for (int r = 0; r < 12; r++) begin
         int         s;
         logic [3:0] act;
         bit         inj;
         s   = int'($urandom_range(0, 1));
         act = 4'($urandom);
         inj = 1'($urandom);
         run_sweep(s, act, inj, $sformatf("rnd%0d", r));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
